// File: rtl/bio_debounce.sv
// bio_debounce: 2-flop synchronizers, tick-paced debounce and press/release event pulses
// for three active-low keys and 18 slide switches. Define BIO_DB_REPEAT_EN for key auto-repeat.
module bio_debounce #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8,
  parameter int REP_DELAY    = 500,
  parameter int REP_RATE     = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key3_n,
  input  logic        key2_n,
  input  logic        key1_n,
  input  logic [17:0] sw,
  output logic        key3_db_n,
  output logic        key2_db_n,
  output logic        key1_db_n,
  output logic [17:0] sw_db,
  output logic [2:0]  key_press,
  output logic [2:0]  key_release,
  output logic        tick
);

  localparam int NUM_SW  = 18;
  localparam int NUM_KEY = 3;
  localparam int NUM_CH  = NUM_SW + NUM_KEY;
  localparam int TW      = $clog2(TICK_DIV);

  localparam logic [TW-1:0]     TCNT_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]        CNT_LAST  = 8'(STABLE_TICKS - 1);
  // Keys idle released (high), switches idle off.
  localparam logic [NUM_CH-1:0] DB_RST    = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};

  generate
    if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("bio_debounce: TICK_DIV must be at least 2");
    end
    if (STABLE_TICKS < 1 || STABLE_TICKS > 255) begin : g_bad_stable
      $error("bio_debounce: STABLE_TICKS must be in 1..255");
    end
    if (REP_RATE < 1 || REP_RATE > REP_DELAY || REP_DELAY > 2047) begin : g_bad_repeat
      $error("bio_debounce: need 1 <= REP_RATE <= REP_DELAY <= 2047");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Synchronizers: channel order is sw[17:0], then key1, key2, key3.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] r_sync_p;
  logic [NUM_CH-1:0] r_sync_s;

  assign w_raw = {key3_n, key2_n, key1_n, sw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the synchronizer flops carry no reset; they are pure delay and refill in two cycles.
  always_ff @(posedge clk) begin
    r_sync_p <= w_raw;
    r_sync_s <= r_sync_p;
  end

  // ---------------------------------------------------------------------------
  // Prescaler: tick is registered from the next count so it lines up with
  // the cycle in which the counter sits at its last value.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_tcnt_nxt;
  logic          r_tick;

  assign w_tcnt_nxt = (r_tcnt == TCNT_LAST) ? '0 : r_tcnt + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_tick <= (w_tcnt_nxt == TCNT_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: each channel counts ticks while its synced level differs from
  // the debounced level; any return to the debounced level restarts the count.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]      r_db;
  logic [NUM_CH-1:0]      w_db_nxt;
  logic [NUM_CH-1:0][7:0] r_cnt;
  logic [NUM_CH-1:0][7:0] w_cnt_nxt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_db_nxt  = r_db;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sync_s[i] == r_db[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_tick) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_db_nxt[i]  = r_sync_s[i];
          w_cnt_nxt[i] = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db  <= DB_RST;
      r_cnt <= '0;
    end else begin
      r_db  <= w_db_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Key events: edges of the debounced key levels, registered one cycle later.
  // The delayed copy resets to "released" so reset itself never looks like an edge.
  // ---------------------------------------------------------------------------
  logic [NUM_KEY-1:0] w_key_db;
  logic [NUM_KEY-1:0] r_key_db_d;
  logic [NUM_KEY-1:0] w_fall;
  logic [NUM_KEY-1:0] w_rise;
  logic [NUM_KEY-1:0] w_rep;
  logic [NUM_KEY-1:0] r_press;
  logic [NUM_KEY-1:0] r_release;

  assign w_key_db = r_db[NUM_CH-1:NUM_SW];
  assign w_fall   = r_key_db_d & ~w_key_db;
  assign w_rise   = ~r_key_db_d & w_key_db;

`ifdef BIO_DB_REPEAT_EN
  localparam logic [10:0] HOLD_FIRE   = 11'(REP_DELAY - 1);
  localparam logic [10:0] HOLD_RELOAD = 11'(REP_DELAY - REP_RATE);

  logic [NUM_KEY-1:0][10:0] r_hold;
  logic [NUM_KEY-1:0][10:0] w_hold_nxt;

  // Hold counter restarts on the press edge and advances per tick while held;
  // reloading below the fire point spaces later pulses REP_RATE ticks apart.
  always_comb begin
    w_hold_nxt = r_hold;
    w_rep      = '0;
    for (int k = 0; k < NUM_KEY; k++) begin
      if (w_fall[k]) begin
        w_hold_nxt[k] = '0;
      end else if (!w_key_db[k] && r_tick) begin
        if (r_hold[k] == HOLD_FIRE) begin
          w_rep[k]      = 1'b1;
          w_hold_nxt[k] = HOLD_RELOAD;
        end else begin
          w_hold_nxt[k] = r_hold[k] + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else begin
      r_hold <= w_hold_nxt;
    end
  end
`else
  assign w_rep = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_db_d <= '1;
      r_press    <= '0;
      r_release  <= '0;
    end else begin
      r_key_db_d <= w_key_db;
      r_press    <= w_fall | w_rep;
      r_release  <= w_rise;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sw_db       = r_db[NUM_SW-1:0];
  assign key1_db_n   = r_db[NUM_SW];
  assign key2_db_n   = r_db[NUM_SW+1];
  assign key3_db_n   = r_db[NUM_SW+2];
  assign key_press   = r_press;
  assign key_release = r_release;
  assign tick        = r_tick;

endmodule

// File: tb/tb_bio_debounce.sv
// Scoreboard bench for bio_debounce: stimulus queues every expected output change with
// its cycle number; a negedge monitor pops and compares whenever the outputs change.
module tb_bio_debounce;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int REP_DELAY    = 5;
  localparam int REP_RATE     = 2;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        key3_n = 1'b1;
  logic        key2_n = 1'b1;
  logic        key1_n = 1'b1;
  logic [17:0] sw     = 18'h3FFFF;
  logic        key3_db_n, key2_db_n, key1_db_n;
  logic [17:0] sw_db;
  logic [2:0]  key_press, key_release;
  logic        tick;

  bio_debounce #(
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .REP_DELAY    (REP_DELAY),
    .REP_RATE     (REP_RATE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key3_n      (key3_n),
    .key2_n      (key2_n),
    .key1_n      (key1_n),
    .sw          (sw),
    .key3_db_n   (key3_db_n),
    .key2_db_n   (key2_db_n),
    .key1_db_n   (key1_db_n),
    .sw_db       (sw_db),
    .key_press   (key_press),
    .key_release (key_release),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after the last reset edge (prescaler count 0).
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [2:0]  keys;   // {key3, key2, key1} debounced, active-low
    logic [17:0] sw;
    logic [2:0]  press;
    logic [2:0]  rel;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t  q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;
  snap_t prev;
  snap_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void push(input int c, input logic [2:0] k, input logic [17:0] s,
                               input logic [2:0] p, input logic [2:0] r);
    exp_t e;
    e.cyc     = c;
    e.s.keys  = k;
    e.s.sw    = s;
    e.s.press = p;
    e.s.rel   = r;
    q.push_back(e);
  endfunction

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL wait_cyc: cycle %0d never reached (now %0d)", n, cyc);
        break;
      end
    end
  endtask

  // Monitor: any change of the observable outputs must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {key3_db_n, key2_db_n, key1_db_n, sw_db, key_press, key_release};
      if (cur !== prev) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event (cycle %0d): got %h, expected no change from %h",
                   cyc, cur, prev);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_value", cur, e.s);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for 3 cycles with all switches on and keys released.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_key_db_n", {key3_db_n, key2_db_n, key1_db_n}, 3'b111);
    check("rst_sw_db", sw_db, 18'h0);
    check("rst_key_press", key_press, 3'b000);
    check("rst_key_release", key_release, 3'b000);
    check("rst_tick", tick, 1'b0);
    prev   = {key3_db_n, key2_db_n, key1_db_n, sw_db, key_press, key_release};
    mon_en = 1'b1;

    // Switches already synced: ticks at 3, 7, 11 -> visible in cycle 12.
    push(12, 3'b111, 18'h3FFFF, 3'b000, 3'b000);

    wait_cyc(2);
    @(negedge clk);
    check("tick_idle", tick, 1'b0);
    wait_cyc(3);
    @(negedge clk);
    check("tick_strobe", tick, 1'b1);

    // key1 press at 20: synced from 22, ticks 23/27/31 -> db at 32, pulse at 33.
    wait_cyc(20);
    key1_n = 1'b0;
    push(32, 3'b110, 18'h3FFFF, 3'b000, 3'b000);
    push(33, 3'b110, 18'h3FFFF, 3'b001, 3'b000);
    push(34, 3'b110, 18'h3FFFF, 3'b000, 3'b000);

    // key1 release at 40: ticks 43/47/51 -> db at 52, release pulse at 53.
    wait_cyc(40);
    key1_n = 1'b1;
    push(52, 3'b111, 18'h3FFFF, 3'b000, 3'b000);
    push(53, 3'b111, 18'h3FFFF, 3'b000, 3'b001);
    push(54, 3'b111, 18'h3FFFF, 3'b000, 3'b000);

    // key2 bounce: one-cycle highs at 63 and 68 restart the count; the clean
    // run starts at 69 -> ticks 71/75/79 -> db at 80 (72 if bounces ignored).
    wait_cyc(60);
    key2_n = 1'b0;
    wait_cyc(63);
    key2_n = 1'b1;
    wait_cyc(64);
    key2_n = 1'b0;
    wait_cyc(68);
    key2_n = 1'b1;
    wait_cyc(69);
    key2_n = 1'b0;
    push(80, 3'b101, 18'h3FFFF, 3'b000, 3'b000);
    push(81, 3'b101, 18'h3FFFF, 3'b010, 3'b000);
    push(82, 3'b101, 18'h3FFFF, 3'b000, 3'b000);

    wait_cyc(90);
    key2_n = 1'b1;
    push(104, 3'b111, 18'h3FFFF, 3'b000, 3'b000);
    push(105, 3'b111, 18'h3FFFF, 3'b000, 3'b010);
    push(106, 3'b111, 18'h3FFFF, 3'b000, 3'b000);

    // key3 and sw[5] in the same cycle: both change together at 132.
    wait_cyc(120);
    key3_n = 1'b0;
    sw[5]  = 1'b0;
    push(132, 3'b011, 18'h3FFDF, 3'b000, 3'b000);
    push(133, 3'b011, 18'h3FFDF, 3'b100, 3'b000);
    push(134, 3'b011, 18'h3FFDF, 3'b000, 3'b000);

    wait_cyc(140);
    key3_n = 1'b1;
    sw[5]  = 1'b1;
    push(152, 3'b111, 18'h3FFFF, 3'b000, 3'b000);
    push(153, 3'b111, 18'h3FFFF, 3'b000, 3'b100);
    push(154, 3'b111, 18'h3FFFF, 3'b000, 3'b000);

    // key3 pressed (db low from 168), then key1 counting (2 after tick 167)
    // when reset hits in cycle 171.
    wait_cyc(156);
    key3_n = 1'b0;
    push(168, 3'b011, 18'h3FFFF, 3'b000, 3'b000);
    push(169, 3'b011, 18'h3FFFF, 3'b100, 3'b000);
    push(170, 3'b011, 18'h3FFFF, 3'b000, 3'b000);
    wait_cyc(160);
    key1_n = 1'b0;

    wait_cyc(171);
    rst    = 1'b1;
    key3_n = 1'b1;
    // Reset returns key3 high and switches off with no release pulse.
    push(0, 3'b111, 18'h0, 3'b000, 3'b000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fresh count: ticks 3/7/11 -> key1 and switches both re-debounce at 12.
    push(12, 3'b110, 18'h3FFFF, 3'b000, 3'b000);
    push(13, 3'b110, 18'h3FFFF, 3'b001, 3'b000);
    push(14, 3'b110, 18'h3FFFF, 3'b000, 3'b000);
`ifdef BIO_DB_REPEAT_EN
    // Ticks after the press: 15 is the 1st, so 31/39/47/55 are the 5th/7th/9th/11th.
    push(32, 3'b110, 18'h3FFFF, 3'b001, 3'b000);
    push(33, 3'b110, 18'h3FFFF, 3'b000, 3'b000);
    push(40, 3'b110, 18'h3FFFF, 3'b001, 3'b000);
    push(41, 3'b110, 18'h3FFFF, 3'b000, 3'b000);
    push(48, 3'b110, 18'h3FFFF, 3'b001, 3'b000);
    push(49, 3'b110, 18'h3FFFF, 3'b000, 3'b000);
    push(56, 3'b110, 18'h3FFFF, 3'b001, 3'b000);
    push(57, 3'b110, 18'h3FFFF, 3'b000, 3'b000);
`endif
    // Release at 48: ticks 51/55/59 -> db high at 60, before the tick-63 repeat.
    wait_cyc(48);
    key1_n = 1'b1;
    push(60, 3'b111, 18'h3FFFF, 3'b000, 3'b000);
    push(61, 3'b111, 18'h3FFFF, 3'b000, 3'b001);
    push(62, 3'b111, 18'h3FFFF, 3'b000, 3'b000);

    wait_cyc(100);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
